noise_channel_gen: RTL and testbench

//  Parametrised APU noise channel: LFSR noise source, volume envelope, frequency timer, length counter, CPU register port.

---
 rtl/noise_channel_gen_pkg.sv | 26 ++
 rtl/noise_channel_gen_lfsr.sv | 34 +++
 rtl/noise_channel_gen.sv | 163 ++++++++++++++++
 tb/tb_noise_channel_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_channel_gen_pkg.sv
// Shared constants for the noise channel: register select bits, field positions
// and the timer period helper.
package noise_channel_gen_pkg;

    // Bit positions inside the one-hot target select (NRx1 is bit 0).
    localparam int NRX1 = 0;
    localparam int NRX2 = 1;
    localparam int NRX3 = 2;
    localparam int NRX4 = 3;

    localparam int NR2_DIR_BIT    = 3;
    localparam int NR3_SHORT_BIT  = 3;
    localparam int NR4_LEN_EN_BIT = 6;
    localparam int NR4_TRIG_BIT   = 7;

    localparam logic [3:0] ENV_MAX    = 4'hF;
    localparam logic [3:0] SHIFT_STOP = 4'd14;

    // Timer reload value in slow ticks for divisor code r and shift s.
    function automatic logic [31:0] noise_period(input logic [2:0] r, input logic [3:0] s);
        logic [31:0] base;
        base = (r == 3'd0) ? 32'd4 : {26'd0, r, 3'b000};
        return base << s;
    endfunction

endpackage

// File: rtl/noise_channel_gen_lfsr.sv
// Noise LFSR: shifts right with feedback l[0]^l[1] into the MSB, and in short
// mode also into bit SHORT_W-1. init (trigger) takes priority over step.
module noise_lfsr #(
    parameter int LFSR_W  = 15,
    parameter int SHORT_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              step,
    input  logic              short_mode,
    output logic [LFSR_W-1:0] state
);

    logic              fb;
    logic [LFSR_W-1:0] shifted;

    always_comb begin
        fb      = state[0] ^ state[1];
        shifted = {fb, state[LFSR_W-1:1]};
        if (short_mode) begin
            shifted[SHORT_W-1] = fb;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || init) begin
            state <= '1;
        end else if (step) begin
            state <= shifted;
        end
    end

endmodule

// File: rtl/noise_channel_gen.sv
// APU noise channel: register port, frequency timer driving the noise LFSR,
// volume envelope and length counter, with DAC gating of the active flag.
module noise_channel_gen
    import noise_channel_gen_pkg::*;
#(
    parameter int LFSR_W  = 15,
    parameter int SHORT_W = 7,
    parameter int LEN_W   = 6,
    parameter int AMP_W   = 4,
    parameter int TIMER_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slow_clk_en,
    input  logic              cpu_en,
    input  logic              env_clk_en,
    input  logic              len_clk_en,
    input  logic [3:0]        target,
    input  logic [7:0]        wdata,
    input  logic              write,
    output logic [7:0]        rdata,
    output logic [AMP_W-1:0]  wave,
    output logic [AMP_W-1:0]  volume_out,
    output logic              active,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] LEN_ONE  = (LEN_W+1)'(1);

    logic [7:0]         nr2;
    logic [7:0]         nr3;
    logic               len_en;
    logic [LEN_W:0]     len_cnt;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         amp;
    logic [2:0]         env_cnt;
    logic               active_r;

    logic               wr_en, wr1, wr2, wr3, wr4, trigger;
    logic               dac_on, frozen, timer_fire, len_step;
    logic [2:0]         env_per;
    logic [TIMER_W-1:0] period;
    logic [AMP_W-1:0]   amp_scaled;

    assign wr_en   = cpu_en & write;
    assign wr1     = wr_en & target[NRX1];
    assign wr2     = wr_en & target[NRX2];
    assign wr3     = wr_en & target[NRX3];
    assign wr4     = wr_en & target[NRX4];
    assign trigger = wr4 & wdata[NR4_TRIG_BIT];

    assign dac_on  = |nr2[7:3];
    assign env_per = nr2[2:0];
    assign frozen  = nr3[7:4] >= SHIFT_STOP;
    assign period  = TIMER_W'(noise_period(nr3[2:0], nr3[7:4]));

    // A trigger on the same edge reseeds the LFSR, so the step is simply overridden.
    assign timer_fire = slow_clk_en & ~frozen & (timer <= TIMER_W'(1));
    // Length ticks lose to an NRx1 reload and to a trigger on the same edge.
    assign len_step   = len_clk_en & len_en & (len_cnt != '0) & ~wr1 & ~trigger;

    always_ff @(posedge clk) begin
        if (!reset) begin
            nr2 <= '0;
            nr3 <= '0;
        end else begin
            if (wr2) nr2 <= wdata;
            if (wr3) nr3 <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer <= '0;
        end else if (trigger) begin
            timer <= period;
        end else if (slow_clk_en && !frozen) begin
            timer <= timer_fire ? period : timer - TIMER_W'(1);
        end
    end

    // Envelope steps use the stored per/dir, so an NRx2 write only affects later ticks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            amp     <= '0;
            env_cnt <= '0;
        end else if (trigger) begin
            amp     <= nr2[7:4];
            env_cnt <= env_per;
        end else if (env_clk_en && env_per != 3'd0) begin
            if (env_cnt <= 3'd1) begin
                env_cnt <= env_per;
                if (nr2[NR2_DIR_BIT] && amp != ENV_MAX) begin
                    amp <= amp + 4'd1;
                end else if (!nr2[NR2_DIR_BIT] && amp != 4'd0) begin
                    amp <= amp - 4'd1;
                end
            end else begin
                env_cnt <= env_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len_en  <= 1'b0;
            len_cnt <= '0;
        end else begin
            if (wr4) len_en <= wdata[NR4_LEN_EN_BIT];
            if (trigger) begin
                if (len_cnt == '0) len_cnt <= LEN_FULL;
            end else if (wr1) begin
                len_cnt <= LEN_FULL - {1'b0, wdata[LEN_W-1:0]};
            end else if (len_step) begin
                len_cnt <= len_cnt - LEN_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_r <= 1'b0;
        end else if (trigger) begin
            active_r <= dac_on;
        end else if (wr2 && wdata[7:3] == 5'd0) begin
            active_r <= 1'b0;
        end else if (len_step && len_cnt == LEN_ONE) begin
            active_r <= 1'b0;
        end
    end

    noise_lfsr #(
        .LFSR_W (LFSR_W),
        .SHORT_W(SHORT_W)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .init      (trigger),
        .step      (timer_fire),
        .short_mode(nr3[NR3_SHORT_BIT]),
        .state     (lfsr_state)
    );

    always_comb begin
        rdata = 8'hFF;
        if (target[NRX1]) begin
            rdata = 8'hFF;
        end else if (target[NRX2]) begin
            rdata = nr2;
        end else if (target[NRX3]) begin
            rdata = nr3;
        end else if (target[NRX4]) begin
            rdata = {1'b1, len_en, 6'h3F};
        end
    end

    assign amp_scaled = AMP_W'(amp) << (AMP_W - 4);
    assign active     = active_r;
    assign volume_out = active_r ? amp_scaled : '0;
    assign wave       = (active_r && !lfsr_state[0]) ? amp_scaled : '0;

endmodule

// File: tb/tb_noise_channel_gen.sv
// Bench for noise_channel_gen: vector table, directed corner sequences and a
// randomized run checked against an integer model of the channel.
module tb_noise_channel_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        slow_clk_en = 1'b0, cpu_en = 1'b0, env_clk_en = 1'b0, len_clk_en = 1'b0, write = 1'b0;
    logic [3:0]  target = 4'h0;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic [3:0]  wave, volume_out;
    logic        active;
    logic [14:0] lfsr_state;

    int total = 0;
    int bad   = 0;

    // Model state held as plain integers.
    int m_nr2, m_nr3, m_len, m_timer, m_lfsr, m_amp, m_env;
    bit m_len_en, m_active;

    typedef struct {
        bit          rst_n;
        bit          slow;
        bit          wr;
        logic [3:0]  tgt;
        logic [7:0]  wd;
        logic [14:0] e_lfsr;
        bit          e_act;
        logic [3:0]  e_vol;
        logic [3:0]  e_wave;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    noise_channel_gen #(
        .LFSR_W(15), .SHORT_W(7), .LEN_W(6), .AMP_W(4), .TIMER_W(22)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .slow_clk_en(slow_clk_en),
        .cpu_en     (cpu_en),
        .env_clk_en (env_clk_en),
        .len_clk_en (len_clk_en),
        .target     (target),
        .wdata      (wdata),
        .write      (write),
        .rdata      (rdata),
        .wave       (wave),
        .volume_out (volume_out),
        .active     (active),
        .lfsr_state (lfsr_state)
    );

    function automatic int lfsr_step(int l, bit short_mode);
        int x;
        x = (l ^ (l >> 1)) & 1;
        l = (l >> 1) | (x << 14);
        if (short_mode) l = (l & ~(1 << 6)) | (x << 6);
        return l;
    endfunction

    function automatic int period_of(int nr3);
        int r, s;
        r = nr3 & 7;
        s = (nr3 >> 4) & 15;
        return ((r == 0) ? 4 : 8 * r) << s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the channel rules to the inputs present at this clock edge.
    task automatic model_edge();
        int  n_nr2, n_nr3, n_len, n_timer, n_lfsr, n_amp, n_env;
        bit  n_len_en, n_active;
        bit  we, w1, w2, w3, w4, trig;
        int  per;
        if (!reset) begin
            m_nr2 = 0; m_nr3 = 0; m_len = 0; m_timer = 0; m_lfsr = 32'h7FFF;
            m_amp = 0; m_env = 0; m_len_en = 0; m_active = 0;
            return;
        end
        n_nr2 = m_nr2; n_nr3 = m_nr3; n_len = m_len; n_timer = m_timer; n_lfsr = m_lfsr;
        n_amp = m_amp; n_env = m_env; n_len_en = m_len_en; n_active = m_active;
        we = cpu_en & write;
        w1 = we & target[0]; w2 = we & target[1]; w3 = we & target[2]; w4 = we & target[3];
        trig = w4 & wdata[7];
        per = m_nr2 & 7;
        if (slow_clk_en && ((m_nr3 >> 4) & 15) < 14) begin
            if (m_timer <= 1) begin
                n_timer = period_of(m_nr3);
                n_lfsr  = lfsr_step(m_lfsr, m_nr3[3]);
            end else begin
                n_timer = m_timer - 1;
            end
        end
        if (env_clk_en && per != 0) begin
            if (m_env <= 1) begin
                n_env = per;
                if ((m_nr2 & 8) != 0) n_amp = (m_amp < 15) ? m_amp + 1 : 15;
                else                  n_amp = (m_amp > 0) ? m_amp - 1 : 0;
            end else begin
                n_env = m_env - 1;
            end
        end
        if (len_clk_en && m_len_en && m_len != 0 && !w1 && !trig) begin
            n_len = m_len - 1;
            if (n_len == 0) n_active = 0;
        end
        if (w1) n_len = 64 - (int'(wdata) & 63);
        if (w2) begin
            n_nr2 = int'(wdata);
            if ((int'(wdata) >> 3) == 0) n_active = 0;
        end
        if (w3) n_nr3 = int'(wdata);
        if (w4) n_len_en = wdata[6];
        if (trig) begin
            n_active = (m_nr2 >> 3) != 0;
            n_lfsr   = 32'h7FFF;
            n_timer  = period_of(m_nr3);
            n_amp    = m_nr2 >> 4;
            n_env    = per;
            n_len    = (m_len == 0) ? 64 : m_len;
        end
        m_nr2 = n_nr2; m_nr3 = n_nr3; m_len = n_len; m_timer = n_timer; m_lfsr = n_lfsr;
        m_amp = n_amp; m_env = n_env; m_len_en = n_len_en; m_active = n_active;
    endtask

    task automatic drive(input bit rst_n, input bit s, input bit e, input bit l,
                         input bit ce, input bit w, input logic [3:0] t, input logic [7:0] d);
        @(negedge clk);
        reset = rst_n; slow_clk_en = s; env_clk_en = e; len_clk_en = l;
        cpu_en = ce; write = w; target = t; wdata = d;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] t, input logic [7:0] d);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t, d);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic slow_ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        int   e, e8;
        logic [3:0] t;
        logic [7:0] d, exp_rd;
        bit   rs, s, en, ln, ce, w;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 15'h7FFF, 1'b0, 4'h0, 4'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'h2, 8'hF0, 15'h7FFF, 1'b0, 4'h0, 4'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'h4, 8'h00, 15'h7FFF, 1'b0, 4'h0, 4'h0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'h8, 8'h80, 15'h7FFF, 1'b1, 4'hF, 4'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 15'h7FFF, 1'b1, 4'hF, 4'h0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 15'h7FFF, 1'b1, 4'hF, 4'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 15'h7FFF, 1'b1, 4'hF, 4'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 15'h3FFF, 1'b1, 4'hF, 4'h0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 15'h3FFF, 1'b1, 4'hF, 4'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 15'h3FFF, 1'b1, 4'hF, 4'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 15'h3FFF, 1'b1, 4'hF, 4'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 15'h1FFF, 1'b1, 4'hF, 4'h0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4'h2, 8'h00, 15'h1FFF, 1'b0, 4'h0, 4'h0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 4'h2, 8'h08, 15'h1FFF, 1'b0, 4'h0, 4'h0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 4'h8, 8'h80, 15'h7FFF, 1'b1, 4'h0, 4'h0};

        // Vector table: reset, basic trigger, LFSR stepping every 4 ticks, DAC gating.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst_n, vecs[i].slow, 1'b0, 1'b0, vecs[i].wr, vecs[i].wr, vecs[i].tgt, vecs[i].wd);
            chk($sformatf("tbl%0d_lfsr", i), 32'(lfsr_state), 32'(vecs[i].e_lfsr));
            chk($sformatf("tbl%0d_active", i), 32'(active), 32'(vecs[i].e_act));
            chk($sformatf("tbl%0d_vol", i), 32'(volume_out), 32'(vecs[i].e_vol));
            chk($sformatf("tbl%0d_wave", i), 32'(wave), 32'(vecs[i].e_wave));
        end

        // Register readback.
        do_reset();
        wr_reg(4'h2, 8'hA1); chk("rd_nr2", 32'(rdata), 32'hA1);
        wr_reg(4'h4, 8'h5C); chk("rd_nr3", 32'(rdata), 32'h5C);
        wr_reg(4'h8, 8'h40); chk("rd_nr4_len1", 32'(rdata), 32'hFF);
        wr_reg(4'h8, 8'h00); chk("rd_nr4_len0", 32'(rdata), 32'hBF);
        wr_reg(4'h1, 8'h10); chk("rd_nr1", 32'(rdata), 32'hFF);
        chk("rd_no_trig_active", 32'(active), 32'h0);

        // Length counter expiry and NRx1 write racing a length tick.
        do_reset();
        wr_reg(4'h2, 8'hF0);
        wr_reg(4'h1, 8'h3E);
        wr_reg(4'h8, 8'hC0); chk("len_trig_active", 32'(active), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00); chk("len_tick1", 32'(active), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00); chk("len_tick2", 32'(active), 32'h0);
        wr_reg(4'h8, 8'hC0); chk("len_retrig", 32'(active), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 8'h3F); chk("len_wr_race", 32'(active), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00); chk("len_after_race", 32'(active), 32'h0);
        wr_reg(4'h8, 8'h80);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        chk("len_disabled_hold", 32'(active), 32'h1);

        // Envelope decay to 0 and rise to 15, both saturating.
        do_reset();
        wr_reg(4'h2, 8'hA1);
        wr_reg(4'h8, 8'h80); chk("env_start_down", 32'(volume_out), 32'd10);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            chk($sformatf("env_down%0d", i), 32'(volume_out), (i < 10) ? 32'(9 - i) : 32'd0);
        end
        chk("env_down_active", 32'(active), 32'h1);
        wr_reg(4'h2, 8'h19);
        wr_reg(4'h8, 8'h80); chk("env_start_up", 32'(volume_out), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            chk($sformatf("env_up%0d", i), 32'(volume_out), (i < 13) ? 32'(2 + i) : 32'd15);
        end

        // Short mode: step-by-step sequence and 127-step period.
        do_reset();
        wr_reg(4'h2, 8'hF0);
        wr_reg(4'h4, 8'h08);
        wr_reg(4'h8, 8'h80);
        e = 32'h7FFF;
        e8 = 0;
        for (int k = 1; k <= 135; k++) begin
            slow_ticks(4);
            e = lfsr_step(e, 1'b1);
            if (k == 8) e8 = e;
            chk($sformatf("short_lfsr%0d", k), 32'(lfsr_state), 32'(e));
            chk($sformatf("short_wave%0d", k), 32'(wave), ((e & 1) != 0) ? 32'd0 : 32'd15);
        end
        chk("short_period127", 32'(lfsr_state), 32'(e8));

        // Shift stop: s=14 freezes the LFSR.
        do_reset();
        wr_reg(4'h2, 8'hF0);
        wr_reg(4'h4, 8'hE0);
        wr_reg(4'h8, 8'h80);
        slow_ticks(10000);
        chk("freeze_lfsr", 32'(lfsr_state), 32'h7FFF);
        chk("freeze_active", 32'(active), 32'h1);

        // Reset mid-note overrides a simultaneous trigger and every tick.
        wr_reg(4'h4, 8'h00);
        wr_reg(4'h8, 8'h80);
        slow_ticks(21);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h8, 8'hC0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_vol", 32'(volume_out), 32'h0);
        chk("rst_wave", 32'(wave), 32'h0);
        chk("rst_lfsr", 32'(lfsr_state), 32'h7FFF);
        chk("rst_rd_nr4", 32'(rdata), 32'hBF);
        slow_ticks(8);
        chk("rst_stays_off", 32'(active), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 8'h00);
        chk("rst_rd_nr2", 32'(rdata), 32'h00);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 199) != 0);
            s  = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 5) == 0);
            ln = ($urandom_range(0, 5) == 0);
            w  = ($urandom_range(0, 3) == 0);
            ce = ($urandom_range(0, 2) != 0);
            t  = 4'(1 << $urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            if (t == 4'h4) begin
                d[7:4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 1));
            end
            drive(rs, s, en, ln, ce, w, t, d);
            case (t)
                4'h2:    exp_rd = 8'(m_nr2);
                4'h4:    exp_rd = 8'(m_nr3);
                4'h8:    exp_rd = {1'b1, m_len_en, 6'h3F};
                default: exp_rd = 8'hFF;
            endcase
            chk("rnd_lfsr", 32'(lfsr_state), 32'(m_lfsr));
            chk("rnd_active", 32'(active), 32'(m_active));
            chk("rnd_vol", 32'(volume_out), m_active ? 32'(m_amp) : 32'd0);
            chk("rnd_wave", 32'(wave), (m_active && (m_lfsr & 1) == 0) ? 32'(m_amp) : 32'd0);
            chk("rnd_rdata", 32'(rdata), 32'(exp_rd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
